// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, constants and the write-winner helper for the
// multi-port register file (regfile_mp) and its read-port sub-module.
//
// Contents:
//   rf_state_t     - controller state (CLEAR sweep / RUN)
//   ZERO_IDX       - index of the hardwired-zero register
//   A0_IDX_DEFAULT - default register mirrored on the a0 output
//   MAX_WR, MAX_AW - widest write-port count / address width the helper handles
//   wr_sel_t       - result of the write-winner search (hit + winning port)
//   rf_wr_winner() - finds the highest-index enabled write port hitting addr
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int ZERO_IDX       = 0;
  localparam int A0_IDX_DEFAULT = 10;

  // The helper works on buses zero-extended to these fixed maxima so it can
  // be shared by modules with different ADDR_WIDTH / NUM_WR settings.
  localparam int MAX_WR   = 2;
  localparam int MAX_AW   = 16;
  localparam int WR_BUS_W = MAX_WR * MAX_AW;

  typedef struct packed {
    logic       hit;
    logic [0:0] port;
  } wr_sel_t;

  // Highest-index matching port wins because later iterations overwrite the
  // result. Address 0 never hits, so register 0 is never written or bypassed.
  function automatic wr_sel_t rf_wr_winner(
    input logic [MAX_WR-1:0]   we,
    input logic [WR_BUS_W-1:0] wr_addr,
    input int                  addr_w,
    input int                  num_wr,
    input logic [MAX_AW-1:0]   addr
  );
    wr_sel_t           sel;
    logic [MAX_AW-1:0] mask;
    logic [MAX_AW-1:0] a_j;
    sel  = '0;
    mask = MAX_AW'((1 << addr_w) - 1);
    for (int j = 0; j < MAX_WR; j++) begin
      a_j = MAX_AW'(wr_addr >> (j * addr_w)) & mask;
      if ((j < num_wr) && we[j] && (addr != MAX_AW'(ZERO_IDX)) && (a_j == addr)) begin
        sel.hit  = 1'b1;
        sel.port = j[0:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_mp.
//
// Selects between the stored array value and the data of the write port
// that wins this cycle for the same address (write-first bypass), forces
// address 0 to read zero, and registers the result (1-cycle latency).
// Output is held at zero during reset and while the clear sweep runs.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   run       - controller is in RUN
//   rs_addr   - read address for this port
//   arr_data  - array contents at rs_addr (before this edge's writes)
//   we        - write enables, zero-extended to MAX_WR
//   wr_addr   - packed write addresses, zero-extended to WR_BUS_W
//   wr_data   - packed write data
//   rd_data   - registered read data
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [ADDR_WIDTH-1:0]        rs_addr,
  input  logic [DATA_WIDTH-1:0]        arr_data,
  input  logic [MAX_WR-1:0]            we,
  input  logic [WR_BUS_W-1:0]          wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  wr_sel_t               sel_p0;
  logic [DATA_WIDTH-1:0] byp_p0;
  logic [DATA_WIDTH-1:0] rd_p1;

  // ---- stage p0: bypass select ----
  always_comb begin
    sel_p0 = rf_wr_winner(we, wr_addr, ADDR_WIDTH, NUM_WR, MAX_AW'(rs_addr));
  end

  always_comb begin
    byp_p0 = '0;
    if (rs_addr != ADDR_WIDTH'(ZERO_IDX)) begin
      if (sel_p0.hit)
        byp_p0 = wr_data[int'(sel_p0.port)*DATA_WIDTH +: DATA_WIDTH];
      else
        byp_p0 = arr_data;
    end
  end

  // ---- stage p1: registered output ----
  always_ff @(posedge clk) begin
    if (rst || !run)
      rd_p1 <= '0;
    else
      rd_p1 <= byp_p0;
  end

  assign rd_data = rd_p1;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//
// NUM_WR write ports (highest index wins on an address collision), NUM_RD
// registered read ports with write-first bypass, hardwired-zero register 0,
// and a registered mirror of register A0_IDX on a0. A synchronous reset
// starts a hardware sweep that zeroes registers 1..NUM_REGS-1; ready rises
// on the edge that clears the last register, and writes are ignored until
// then.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset, restarts the clear sweep
//   ready    - file cleared and accepting traffic
//   rs_addr  - packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  - packed registered read data, same packing
//   we       - per-port write enables
//   wr_addr  - packed write addresses
//   wr_data  - packed write data
//   a0       - registered copy of register A0_IDX
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int A0_IDX     = A0_IDX_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0]        a0
);

  localparam int LAST_IDX = NUM_REGS - 1;

  if (ADDR_WIDTH != $clog2(NUM_REGS)) begin : g_bad_addr_width
    $error("regfile_mp: ADDR_WIDTH must equal log2(NUM_REGS)");
  end
  if (NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_bad_num_wr
    $error("regfile_mp: NUM_WR must be 1..2");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be 1..4");
  end

  rf_state_t             state_q;
  rf_state_t             state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_d;
  logic                  ready_q;
  logic                  ready_d;
  logic                  run;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  logic [MAX_WR-1:0]     we_ext;
  logic [WR_BUS_W-1:0]   wr_addr_ext;
  logic                  wr_hit_p0 [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_val_p0 [NUM_REGS];
  logic [DATA_WIDTH-1:0] a0_next_p0;
  logic [DATA_WIDTH-1:0] a0_p1;

  assign we_ext      = MAX_WR'(we);
  assign wr_addr_ext = WR_BUS_W'(wr_addr);
  assign run         = (state_q == RUN);

  // ---- controller: clear sweep / run ----
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        // Leave CLEAR on the last register instead of incrementing, so the
        // pointer never wraps.
        if (clr_ptr_q == ADDR_WIDTH'(LAST_IDX))
          state_d = RUN;
        else
          clr_ptr_d = clr_ptr_q + 1'b1;
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= ADDR_WIDTH'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;

  // ---- stage p0: write decode, one winner per register ----
  always_comb begin
    wr_sel_t wsel;
    wsel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wsel         = rf_wr_winner(we_ext, wr_addr_ext, ADDR_WIDTH, NUM_WR, MAX_AW'(k));
      wr_hit_p0[k] = wsel.hit;
      wr_val_p0[k] = wr_data[int'(wsel.port)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Register 0 is never stored; every reader forces it to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clr_ptr_q] <= '0;
      end else begin
        for (int k = ZERO_IDX + 1; k < NUM_REGS; k++) begin
          if (wr_hit_p0[k])
            mem[k] <= wr_val_p0[k];
        end
      end
    end
  end

  // a0 follows the post-write value of its register, matching the bypass
  // the read ports apply.
  always_comb begin
    a0_next_p0 = '0;
    if (A0_IDX != ZERO_IDX) begin
      if (wr_hit_p0[A0_IDX])
        a0_next_p0 = wr_val_p0[A0_IDX];
      else
        a0_next_p0 = mem[A0_IDX];
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk) begin
    if (rst || !run)
      a0_p1 <= '0;
    else
      a0_p1 <= a0_next_p0;
  end

  assign a0 = a0_p1;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WR     (NUM_WR)
    ) u_rd_port (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .rs_addr  (rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .arr_data (mem[rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
      .we       (we_ext),
      .wr_addr  (wr_addr_ext),
      .wr_data  (wr_data),
      .rd_data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default parameters).
// A behavioural model applies the register-file rules at each rising edge;
// a compare process checks ready, every rd_data port and a0 against it on
// each falling edge once the first reset has been seen. Directed scenarios
// add literal expectations.
module tb_regfile_mp;

  localparam int NR   = 2;
  localparam int NW   = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int A0I  = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           ready;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [DW-1:0]    a0;

  regfile_mp #(
    .NUM_REGS   (NREG),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .NUM_WR     (NW),
    .A0_IDX     (A0I)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .rs_addr (rs_addr),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .a0      (a0)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Behavioural model: contents as a plain array, the sweep as a countdown.
  logic [DW-1:0] m_mem [NREG];
  logic [DW-1:0] m_rd  [NR];
  logic [DW-1:0] m_a0;
  logic          m_ready;
  bit            m_started = 0;
  bit            m_run     = 0;
  int            m_left    = 0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_started = 1;
      m_run     = 0;
      m_ready   = 0;
      m_left    = NREG - 1;
      for (int k = 0; k < NREG; k++) m_mem[k] = '0;
      for (int i = 0; i < NR; i++) m_rd[i] = '0;
      m_a0 = '0;
    end else if (m_started) begin
      if (!m_run) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_run   = 1;
          m_ready = 1;
        end
        for (int i = 0; i < NR; i++) m_rd[i] = '0;
        m_a0 = '0;
      end else begin
        // Port order 0..NW-1: a later port overwrites an earlier one.
        for (int j = 0; j < NW; j++) begin
          if (we[j] && wr_addr[j*AW +: AW] != '0)
            m_mem[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
        end
        for (int i = 0; i < NR; i++) begin
          if (rs_addr[i*AW +: AW] == '0) m_rd[i] = '0;
          else                           m_rd[i] = m_mem[rs_addr[i*AW +: AW]];
        end
        m_a0 = m_mem[A0I];
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("ready", DW'(ready), DW'(m_ready));
      for (int i = 0; i < NR; i++)
        check($sformatf("rd_data[%0d]", i), rd_data[i*DW +: DW], m_rd[i]);
      check("a0", a0, m_a0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    we      = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    we[p]             = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst     = 1'b1;
    rs_addr = '0;
    idle();

    // 1: clear sweep after a one-cycle reset
    cyc();
    check("t1_ready_in_rst", DW'(ready), 32'd0);
    check("t1_a0_in_rst", a0, 32'd0);
    rst = 1'b0;
    wait_ready(n);
    check("t1_sweep_len", DW'(n), 32'd31);
    for (int a = 0; a < NREG; a += 2) begin
      rd(0, a);
      rd(1, a + 1);
      cyc();
      check($sformatf("t1_rd_%0d", a), rd_data[0 +: DW], 32'd0);
      check($sformatf("t1_rd_%0d", a + 1), rd_data[DW +: DW], 32'd0);
    end
    check("t1_a0", a0, 32'd0);

    // 2: basic write then read
    wr(0, 5, 32'hDEADBEEF);
    cyc();
    idle();
    rd(0, 5);
    cyc();
    check("t2_rd5", rd_data[0 +: DW], 32'hDEADBEEF);

    // 3: same-cycle bypass, and address 0 stays zero
    wr(0, 7, 32'h0000_1234);
    rd(1, 7);
    cyc();
    check("t3_bypass", rd_data[DW +: DW], 32'h0000_1234);
    idle();
    wr(0, 0, 32'h0000_FFFF);
    rd(0, 0);
    cyc();
    check("t3_zero_reg", rd_data[0 +: DW], 32'd0);

    // 4: collision, highest port wins; a0 tracks its register
    idle();
    wr(0, 3, 32'h0000_AAAA);
    wr(1, 3, 32'h0000_5555);
    rd(0, 3);
    cyc();
    check("t4_collide_bypass", rd_data[0 +: DW], 32'h0000_5555);
    idle();
    rd(1, 3);
    cyc();
    check("t4_collide_stored", rd_data[DW +: DW], 32'h0000_5555);
    wr(0, 10, 32'h0000_0042);
    cyc();
    check("t4_a0", a0, 32'h0000_0042);
    idle();

    // extra patterns: two ports to different registers, both read back
    for (int i = 0; i < 6; i++) begin
      wr(0, 11 + i, 32'h1000_0000 + DW'(i));
      wr(1, 31 - i, 32'hF000_0000 ^ DW'(i * 3));
      rd(0, 11 + i);
      rd(1, (i % 2 == 0) ? 31 - i : 5);
      cyc();
    end
    idle();
    rd(0, 13);
    rd(1, 29);
    cyc();
    check("tx_rd13", rd_data[0 +: DW], 32'h1000_0002);
    check("tx_rd29", rd_data[DW +: DW], 32'hF000_0006);

    // 5: reset mid-run with a write presented during reset
    check("t5_a0_before", a0, 32'h0000_0042);
    rst = 1'b1;
    wr(0, 4, 32'h0000_0099);
    cyc();
    check("t5_ready_drop", DW'(ready), 32'd0);
    check("t5_a0_drop", a0, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    idle();
    wait_ready(n);
    check("t5_sweep_len", DW'(n), 32'd31);
    rd(0, 4);
    rd(1, 10);
    cyc();
    check("t5_rd4", rd_data[0 +: DW], 32'd0);
    check("t5_rd10", rd_data[DW +: DW], 32'd0);
    check("t5_a0_after", a0, 32'd0);

    // 6: writes during the sweep are ignored
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(0, 20, 32'h0000_0077);
    wait_ready(n);
    check("t6_sweep_len", DW'(n), 32'd31);
    idle();
    rd(0, 20);
    cyc();
    check("t6_rd20", rd_data[0 +: DW], 32'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
